issue_ctrl: RTL

ISSUE_CTRL -- requirements
Module: issue_ctrl

---
 rtl/issue_ctrl_pkg.sv | 45 ++++
 rtl/issue_scoreboard.sv | 68 ++++++
 rtl/issue_ctrl.sv | 109 ++++++++++
 3 files changed

// File: rtl/issue_ctrl_pkg.sv
// rtl/issue_ctrl_pkg.sv - opcode constants, FSM encodings and instruction classification for issue_ctrl
package issue_ctrl_pkg;

  localparam int CNT_W = 4;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    ST_ISSUE  = 2'd0,
    ST_HAZARD = 2'd1,
    ST_DRAIN  = 2'd2
  } ctrl_state_e;

  // U-type and JAL carry no rs1 operand.
  function automatic logic uses_rs1(input logic [6:0] op);
    return !(op == OPC_LUI || op == OPC_AUIPC || op == OPC_JAL);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OPC_BRANCH || op == OPC_STORE || op == OPC_OP);
  endfunction

  // x0 writes never occupy the scoreboard.
  function automatic logic writes_rd(input logic [6:0] op, input logic [4:0] rd);
    logic wr;
    case (op)
      OPC_BRANCH, OPC_STORE, OPC_FENCE: wr = 1'b0;
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
      OPC_LOAD, OPC_OP_IMM, OPC_OP, OPC_SYSTEM: wr = 1'b1;
      default: wr = 1'b1;
    endcase
    return wr && (rd != 5'd0);
  endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// rtl/issue_scoreboard.sv - pending-write scoreboard and hazard lookup; ISSUE_WB_BYPASS_EN releases on the write-back cycle
module issue_scoreboard
  import issue_ctrl_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic [4:0] rd,
  input  logic       use_rs1,
  input  logic       use_rs2,
  input  logic       use_rd,
  input  logic       set_en,
  input  logic [4:0] set_rd,
  input  logic       wb_valid,
  input  logic [4:0] wb_rd,
  output logic       hazard,
  output logic       busy
);

  logic [31:0]      pend;
  logic [CNT_W-1:0] count;
  logic             clr;
  logic [31:0]      set_mask;
  logic [31:0]      clr_mask;
  logic [31:0]      look_pend;
  logic [CNT_W-1:0] look_count;

  // A write-back only counts when it retires a register that is actually pending.
  assign clr = wb_valid && pend[wb_rd];

  // One-hot set/clear masks for this cycle's update.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en) set_mask[set_rd] = 1'b1;
    if (clr)    clr_mask[wb_rd]  = 1'b1;
  end

`ifdef ISSUE_WB_BYPASS_EN
  assign look_pend  = pend & ~clr_mask;
  assign look_count = count - {{(CNT_W-1){1'b0}}, clr};
`else
  assign look_pend  = pend;
  assign look_count = count;
`endif

  assign hazard = (use_rs1 && look_pend[rs1]) ||
                  (use_rs2 && look_pend[rs2]) ||
                  (use_rd  && look_pend[rd])  ||
                  (use_rd  && look_count == CNT_W'(MAX_OUTSTANDING));

  assign busy = |pend;

  // Clear before set so a same-register retire/issue leaves the bit held and the count unchanged.
  always_ff @(posedge clock) begin
    if (reset) begin
      pend  <= '0;
      count <= '0;
    end else begin
      pend  <= ((pend & ~clr_mask) | set_mask) & ~32'd1;
      count <= count + {{(CNT_W-1){1'b0}}, set_en} - {{(CNT_W-1){1'b0}}, clr};
    end
  end

endmodule

// File: rtl/issue_ctrl.sv
// rtl/issue_ctrl.sv - in-order issue stage with register scoreboard; ISSUE_WB_BYPASS_EN enables zero-bubble write-back release
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       d_valid,
  output logic       d_ready,
  input  logic [6:0] d_opcode,
  input  logic [4:0] d_rd,
  input  logic [4:0] d_rs1,
  input  logic [4:0] d_rs2,
  output logic       x_valid,
  input  logic       x_ready,
  output logic [6:0] x_opcode,
  output logic [4:0] x_rd,
  output logic [4:0] x_rs1,
  output logic [4:0] x_rs2,
  input  logic       wb_valid,
  input  logic [4:0] wb_rd,
  input  logic       flush,
  output logic       busy,
  output logic [1:0] ctrl_state
);

  ctrl_state_e state;
  logic        is_fence;
  logic        wr;
  logic        hazard;
  logic        accept;
  logic        x_free;

  assign is_fence = (d_opcode == OPC_FENCE);
  assign wr       = writes_rd(d_opcode, d_rd);
  assign x_free   = !x_valid || x_ready;
  assign accept   = d_valid && d_ready;

  issue_scoreboard #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_scoreboard (
    .clock   (clock),
    .reset   (reset),
    .rs1     (d_rs1),
    .rs2     (d_rs2),
    .rd      (d_rd),
    .use_rs1 (uses_rs1(d_opcode)),
    .use_rs2 (uses_rs2(d_opcode)),
    .use_rd  (wr),
    .set_en  (accept && wr),
    .set_rd  (d_rd),
    .wb_valid(wb_valid),
    .wb_rd   (wb_rd),
    .hazard  (hazard),
    .busy    (busy)
  );

  // FENCE is only taken from DRAIN, once every write has retired and execute is empty.
  always_comb begin
    d_ready = 1'b0;
    if (!reset && !flush) begin
      case (state)
        ST_DRAIN: d_ready = !busy && !x_valid;
        default:  d_ready = !is_fence && !hazard && x_free;
      endcase
    end
  end

  // Issue register and control FSM; flush wins over any transition.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_ISSUE;
      x_valid  <= 1'b0;
      x_opcode <= '0;
      x_rd     <= '0;
      x_rs1    <= '0;
      x_rs2    <= '0;
    end else begin
      if (accept) begin
        x_valid  <= 1'b1;
        x_opcode <= d_opcode;
        x_rd     <= d_rd;
        x_rs1    <= d_rs1;
        x_rs2    <= d_rs2;
      end else if (flush || x_ready) begin
        x_valid  <= 1'b0;
      end

      if (flush) begin
        state <= ST_ISSUE;
      end else begin
        case (state)
          ST_DRAIN: begin
            if (accept) state <= ST_ISSUE;
          end
          default: begin
            if (d_valid && is_fence)    state <= ST_DRAIN;
            else if (accept)            state <= ST_ISSUE;
            else if (d_valid && hazard) state <= ST_HAZARD;
          end
        endcase
      end
    end
  end

  assign ctrl_state = state;

endmodule
